neuron_event_rx: RTL
====================

NEURON_EVENT_RX -- requirements
Module: neuron_event_rx

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entry count; legal values 2, 4 or 8 only.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream event byte present.
REQ-005 in_data  input  8  event byte: [7] marker, [6:4] type, [3:0] value.
REQ-006 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-007 out_valid  output  1  decoded event available at FIFO head.
REQ-008 out_ready  input  1  downstream consumes head when out_valid && out_ready.
REQ-009 out_is_spike  output  1  head event is a spike (0 = activation).
REQ-010 out_value  output  4  head event payload.
REQ-011 spike_cnt  output  8  accepted spike events, saturating.
REQ-012 act_cnt  output  8  accepted activation events, saturating.
REQ-013 err_cnt  output  8  accepted malformed events, saturating.
REQ-014 clr_cnt  input  1  synchronous clear of all three counters.
REQ-015 level  output  4  current FIFO occupancy, 0..DEPTH.

Function
REQ-016 Decode: marker=0 -> idle filler, accepted and dropped, no counter change.
REQ-017 Decode: marker=1, type=NEURON_TYPE_SPIKE (3'b001) -> spike event, pushed, spike_cnt +1.
REQ-018 Decode: marker=1, type=NEURON_TYPE_ACT (3'b010) -> activation event, pushed, act_cnt +1.
REQ-019 Decode: marker=1, any other type -> malformed, dropped, err_cnt +1.
REQ-020 FIFO entry: 5 bits {is_spike, value}; ordering strictly first-in first-out.
REQ-021 in_ready = (level != DEPTH), combinational from state only, independent of out_ready and in_valid.
REQ-022 When full, no byte is accepted, including filler and malformed bytes.
REQ-023 out_valid = (level != 0); out_is_spike/out_value driven from head entry, held stable while out_valid && !out_ready.
REQ-024 Latency: byte accepted in cycle N appears at head no earlier than cycle N+1 (no fall-through).
REQ-025 Push and pop in the same cycle: level unchanged, head advances, new entry written at tail.
REQ-026 Push with a dropped byte (filler/malformed) and pop in the same cycle: level decrements by 1.
REQ-027 Pointers: log2(DEPTH)-bit wrap-around read/write indices; level kept separately, 0..DEPTH.
REQ-028 Counters saturate at 8'd255; no wrap.
REQ-029 clr_cnt in the same cycle as an increment: clear wins, counter becomes 0.
REQ-030 clr_cnt does not affect FIFO contents or level.

Reset
REQ-031 rst_n low: level=0, pointers=0, spike_cnt=act_cnt=err_cnt=0, FIFO contents don't-care.
REQ-032 Outputs during and after reset: in_ready=1, out_valid=0, out_is_spike=0, out_value=0 (head masked to 0 when empty).
REQ-033 Reset mid-operation discards all buffered events; no partial pop or push is completed.

Structure
REQ-034 NEURON_TYPE_SPIKE and NEURON_TYPE_ACT come from shared neuron_defs.vh; no local redefinition.
REQ-035 Event field positions (marker bit, type slice, value slice) are defined in neuron_defs.vh, shared with the emitting side.
REQ-036 The FIFO is one sub-module, neuron_evt_fifo (parameterised width/depth, push/pop/level); decode and counters stay in the top.

Verification
REQ-037 Reset, then in_data=8'h9A (spike, value 10) -> next cycle out_valid=1, out_is_spike=1, out_value=4'hA, spike_cnt=1.
REQ-038 Bytes 8'hA3, 8'h05, 8'hF1 with out_ready=0 -> level=1, act_cnt=1, err_cnt=1, head is_spike=0, value=3.
REQ-039 out_ready=0, push 5 valid spikes at DEPTH=4 -> in_ready=0 after 4th; 5th held until one pop, then accepted; order preserved.
REQ-040 Level=2, push spike and pop in one cycle -> level stays 2; filler plus pop -> level 1.
REQ-041 Drive 300 spikes with out_ready=1 -> spike_cnt=255; then clr_cnt with a simultaneous spike -> spike_cnt=0.
REQ-042 Reset asserted with level=3 -> asynchronously out_valid=0, level=0, in_ready=1, counters 0.

Source files
------------

// File: rtl/neuron_event_rx_pkg.sv
// Shared event-format definitions for the neuron event link.
// Holds the byte field positions and type codes that the emitting side also
// uses, the decoded event record, and small decode/counter helpers.
package neuron_event_rx_pkg;

  // Event byte layout: [7] marker, [6:4] type, [3:0] value
  localparam int EVT_MARK_BIT = 7;
  localparam int EVT_TYPE_HI  = 6;
  localparam int EVT_TYPE_LO  = 4;
  localparam int EVT_VAL_HI   = 3;
  localparam int EVT_VAL_LO   = 0;

  localparam logic [2:0] NEURON_TYPE_SPIKE = 3'b001;
  localparam logic [2:0] NEURON_TYPE_ACT   = 3'b010;

  localparam int         CNT_W   = 8;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {EV_FILL, EV_SPIKE, EV_ACT, EV_BAD} ev_kind_e;

  // One FIFO entry
  typedef struct packed {
    logic       is_spike;
    logic [3:0] value;
  } evt_t;

  function automatic ev_kind_e decode_kind(input logic [7:0] b);
    logic [2:0] t;
    t = b[EVT_TYPE_HI:EVT_TYPE_LO];
    if (!b[EVT_MARK_BIT])            return EV_FILL;
    else if (t == NEURON_TYPE_SPIKE) return EV_SPIKE;
    else if (t == NEURON_TYPE_ACT)   return EV_ACT;
    else                             return EV_BAD;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/neuron_evt_fifo.sv
// Small synchronous FIFO for decoded neuron events.
// Ports: clk/rst_n; i_push/i_din write side (ignored when full);
// i_pop read side (ignored when empty); o_dout head entry (0 when empty);
// o_full, o_empty, o_level occupancy 0..DEPTH.
// DEPTH must be a power of two (2, 4 or 8) so the pointers wrap naturally.
module neuron_evt_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic [3:0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [3:0]    r_level;
  logic          w_push, w_pop;

  assign o_full  = (r_level == 4'(DEPTH));
  assign o_empty = (r_level == 4'd0);
  assign o_level = r_level;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Head masked so outputs read 0 whenever nothing is buffered.
  assign o_dout = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 4'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once level covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/neuron_event_rx.sv
// Neuron event receiver: decodes incoming event bytes, buffers spike and
// activation events in a FIFO, and counts spikes, activations and malformed
// bytes with saturating counters.
// Ports: in_valid/in_data/in_ready byte input; out_valid/out_ready/
// out_is_spike/out_value decoded event output; spike_cnt/act_cnt/err_cnt
// counters, clr_cnt synchronous clear; level FIFO occupancy.
module neuron_event_rx
  import neuron_event_rx_pkg::*;
#(
  parameter int DEPTH = 4   // 2, 4 or 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_spike,
  output logic [3:0]       out_value,
  output logic [CNT_W-1:0] spike_cnt,
  output logic [CNT_W-1:0] act_cnt,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt,
  output logic [3:0]       level
);
  ev_kind_e w_kind;
  evt_t     w_evt, w_head;
  logic     w_acc, w_push, w_pop, w_full, w_empty;

  logic [CNT_W-1:0] r_spike_cnt, r_act_cnt, r_err_cnt;

  // Acceptance depends only on FIFO state; filler and malformed bytes are
  // also refused when full.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_acc     = in_valid && in_ready;
  assign w_kind    = decode_kind(in_data);
  assign w_push    = w_acc && (w_kind == EV_SPIKE || w_kind == EV_ACT);
  assign w_pop     = out_valid && out_ready;

  assign w_evt.is_spike = (w_kind == EV_SPIKE);
  assign w_evt.value    = in_data[EVT_VAL_HI:EVT_VAL_LO];

  neuron_evt_fifo #(.W($bits(evt_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_evt),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_is_spike = w_head.is_spike;
  assign out_value    = w_head.value;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_cnt <= '0;
      r_act_cnt   <= '0;
      r_err_cnt   <= '0;
    end else if (clr_cnt) begin
      r_spike_cnt <= '0;
      r_act_cnt   <= '0;
      r_err_cnt   <= '0;
    end else if (w_acc) begin
      if (w_kind == EV_SPIKE) r_spike_cnt <= sat_inc(r_spike_cnt);
      if (w_kind == EV_ACT)   r_act_cnt   <= sat_inc(r_act_cnt);
      if (w_kind == EV_BAD)   r_err_cnt   <= sat_inc(r_err_cnt);
    end
  end

  assign spike_cnt = r_spike_cnt;
  assign act_cnt   = r_act_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
